// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the ticket machine payout side.
// Coin codes map to values 1, 5, 10 and 20 currency units.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TICKET,
    COIN,
    DONE,
    FAULT
  } state_t;

  localparam logic [1:0] COIN_1  = 2'd0;
  localparam logic [1:0] COIN_5  = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;
  localparam logic [1:0] COIN_20 = 2'd3;

  function automatic logic [7:0] denom_value(input logic [1:0] code);
    logic [7:0] v;
    case (code)
      COIN_20: v = 8'd20;
      COIN_10: v = 8'd10;
      COIN_5:  v = 8'd5;
      default: v = 8'd1;
    endcase
    return v;
  endfunction

  // Largest coin not exceeding the amount; an amount of 0 yields COIN_1.
  function automatic logic [1:0] pick_denom(input logic [7:0] amount);
    logic [1:0] c;
    if (amount >= 8'd20)      c = COIN_20;
    else if (amount >= 8'd10) c = COIN_10;
    else if (amount >= 8'd5)  c = COIN_5;
    else                      c = COIN_1;
    return c;
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive cycles an item is offered without acknowledgement.
// expired is raised during the ACK_TIMEOUT-th such cycle.
module ack_watchdog #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic wait_en,
  input  logic kick,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(ACK_TIMEOUT - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (clr || kick || !wait_en) cnt <= '0;
    else                              cnt <= cnt + 16'd1;
  end

  assign expired = wait_en && (cnt == LIMIT);

endmodule

// File: rtl/change_dispenser.sv
// Payout controller: issues tickets, then greedy coin change, each item as
// a valid/ack handshake guarded by an acknowledgement watchdog.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] change_amt,
  input  logic [2:0] ticket_cnt,
  output logic       ticket_valid,
  input  logic       ticket_ack,
  output logic       coin_valid,
  output logic [1:0] coin_denom,
  input  logic       coin_ack,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] paid_total
);

  state_t     state, state_n;
  logic [2:0] tickets_left, tickets_left_n;
  logic [7:0] change_left, change_left_n;
  logic [7:0] paid_n;
  logic [1:0] denom;
  logic [7:0] denom_val;
  logic       tick_acc, coin_acc, wait_en, kick, expired;

  assign denom     = pick_denom(change_left);
  assign denom_val = denom_value(denom);

  assign ticket_valid = (state == TICKET);
  assign coin_valid   = (state == COIN);
  assign coin_denom   = coin_valid ? denom : COIN_1;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign fault        = (state == FAULT);

  // Acks coinciding with clr are dropped so counters stay untouched.
  assign tick_acc = ticket_valid && ticket_ack && !clr;
  assign coin_acc = coin_valid && coin_ack && !clr;
  assign wait_en  = (ticket_valid && !ticket_ack) || (coin_valid && !coin_ack);
  assign kick     = tick_acc || coin_acc || (state_n != state);

  ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .wait_en(wait_en),
    .kick   (kick),
    .expired(expired)
  );

  always_comb begin
    state_n        = state;
    tickets_left_n = tickets_left;
    change_left_n  = change_left;
    paid_n         = paid_total;
    if (clr) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tickets_left_n = ticket_cnt;
            change_left_n  = change_amt;
            paid_n         = 8'd0;
            if (ticket_cnt != 3'd0)     state_n = TICKET;
            else if (change_amt != 8'd0) state_n = COIN;
            else                         state_n = DONE;
          end
        end
        TICKET: begin
          if (tick_acc) begin
            tickets_left_n = tickets_left - 3'd1;
            if (tickets_left == 3'd1)
              state_n = (change_left != 8'd0) ? COIN : DONE;
          end else if (expired) begin
            state_n = FAULT;
          end
        end
        COIN: begin
          if (coin_acc) begin
            change_left_n = change_left - denom_val;
            paid_n        = paid_total + denom_val;
            if (change_left == denom_val) state_n = DONE;
          end else if (expired) begin
            state_n = FAULT;
          end
        end
        DONE:    state_n = IDLE;
        FAULT:   state_n = FAULT;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tickets_left <= 3'd0;
      change_left  <= 8'd0;
      paid_total   <= 8'd0;
    end else begin
      state        <= state_n;
      tickets_left <= tickets_left_n;
      change_left  <= change_left_n;
      paid_total   <= paid_n;
    end
  end

endmodule
